// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC request from the datapath, instruction-memory handshake, and decoder-facing IR.
// master = instr_fetch, slave = the surrounding PC/memory/decode logic.
interface instr_fetch_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] pc_in;
    logic          fetch_start;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] ir_out;
    logic          instr_valid;
    logic          ir_ack;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] pc_plus4;
    logic          busy;
    logic          fault;

    modport master (
        input  pc_in, fetch_start, imem_ready, imem_rvalid, imem_rdata, ir_ack,
        output imem_req, imem_addr, ir_out, instr_valid, pc_out, pc_plus4, busy, fault
    );

    modport slave (
        output pc_in, fetch_start, imem_ready, imem_rvalid, imem_rdata, ir_ack,
        input  imem_req, imem_addr, ir_out, instr_valid, pc_out, pc_plus4, busy, fault
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one 32-bit word per fetch_start over req/ready + rvalid, held in IR until ir_ack.
// Optional WAIT-state timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter logic [DW-1:0] NOP_WORD = '0,
    parameter int unsigned   TMO_CYC  = 15
) (
    input logic         clk,
    input logic         rst,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    if (TMO_CYC == 0) begin : g_bad_tmo
        $error("TMO_CYC must be >= 1");
    end

    state_t        state;
    logic [AW-1:0] pc_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] tmo_cnt;
`endif

    // A new fetch is taken only from IDLE, or from HOLD when the decoder frees the IR.
    logic accept_c;
    logic misaligned_c;
    assign accept_c     = bus.fetch_start &&
                          ((state == S_IDLE) || ((state == S_HOLD) && bus.ir_ack));
    assign misaligned_c = |bus.pc_in[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pc_q            <= '0;
            bus.imem_req    <= 1'b0;
            bus.imem_addr   <= '0;
            bus.ir_out      <= NOP_WORD;
            bus.instr_valid <= 1'b0;
            bus.pc_out      <= '0;
            bus.pc_plus4    <= AW'(4);
            bus.busy        <= 1'b0;
            bus.fault       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
        end else begin
            bus.fault <= 1'b0;

            unique case (state)
                S_REQ: begin
                    if (bus.imem_ready) begin
                        bus.imem_req <= 1'b0;
                        state        <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // Data beats expiry when both land in the same cycle.
                    if (bus.imem_rvalid) begin
                        bus.ir_out      <= bus.imem_rdata;
                        bus.pc_out      <= pc_q;
                        bus.pc_plus4    <= pc_q + AW'(4);
                        bus.instr_valid <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= S_HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TMO_CYC - 1)) begin
                        bus.fault       <= 1'b1;
                        bus.ir_out      <= NOP_WORD;
                        bus.instr_valid <= 1'b0;
                        bus.busy        <= 1'b0;
                        state           <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
`endif
                end
                S_HOLD: begin
                    if (bus.ir_ack) begin
                        bus.instr_valid <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: ;
            endcase

            // Launch overrides the HOLD->IDLE move above for back-to-back fetches.
            if (accept_c) begin
                if (misaligned_c) begin
                    bus.fault    <= 1'b1;
                    bus.ir_out   <= NOP_WORD;
                    bus.pc_out   <= bus.pc_in;
                    bus.pc_plus4 <= bus.pc_in + AW'(4);
                    state        <= S_IDLE;
                end else begin
                    pc_q          <= bus.pc_in;
                    bus.imem_req  <= 1'b1;
                    bus.imem_addr <= {bus.pc_in[AW-1:2], 2'b00};
                    bus.busy      <= 1'b1;
                    state         <= S_REQ;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetches push expected IR/fault results; a monitor pops and compares.
// Timeout cases run only when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if #(.AW(32), .DW(32)) bus ();

    instr_fetch #(.AW(32), .DW(32), .NOP_WORD(32'h0), .TMO_CYC(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        is_fault;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every new instruction or fault pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ((bus.instr_valid && !prev_valid) || bus.fault)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got ir=%h pc=%h fault=%b expected no output",
                         bus.ir_out, bus.pc_out, bus.fault);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_fault", 32'(bus.fault), 32'(mon_e.is_fault));
                chk("sb_ir", bus.ir_out, mon_e.ir);
                chk("sb_pc", bus.pc_out, mon_e.pc);
                if (!mon_e.is_fault) chk("sb_pc4", bus.pc_plus4, mon_e.pc4);
            end
        end
        prev_valid = bus.instr_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},   32'(bus.imem_req), 32'd0);
        chk({tag, "_addr"},  bus.imem_addr, 32'd0);
        chk({tag, "_ir"},    bus.ir_out, 32'd0);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_pc"},    bus.pc_out, 32'd0);
        chk({tag, "_pc4"},   bus.pc_plus4, 32'd4);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
    endtask

    task automatic start(input logic [31:0] pc);
        bus.pc_in       = pc;
        bus.fetch_start = 1'b1;
        tick();
        bus.fetch_start = 1'b0;
    endtask

    // From REQ: stall ready, accept, wait for response, deliver data.
    task automatic finish_xfer(input int ready_wait, input int resp_wait,
                               input logic [31:0] data, input logic [31:0] pc);
        for (int i = 0; i < ready_wait; i++) begin
            chk("req_stall", 32'(bus.imem_req), 32'd1);
            chk("addr_stall", bus.imem_addr, pc & 32'hFFFF_FFFC);
            tick();
        end
        chk("req_on", 32'(bus.imem_req), 32'd1);
        chk("addr", bus.imem_addr, pc & 32'hFFFF_FFFC);
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        chk("req_drop", 32'(bus.imem_req), 32'd0);
        chk("busy_wait", 32'(bus.busy), 32'd1);
        repeat (resp_wait) tick();
        exp_q.push_back('{is_fault: 1'b0, ir: data, pc: pc, pc4: pc + 32'd4});
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("valid_set", 32'(bus.instr_valid), 32'd1);
        chk("busy_hold", 32'(bus.busy), 32'd0);
    endtask

    task automatic ack();
        bus.ir_ack = 1'b1;
        tick();
        bus.ir_ack = 1'b0;
    endtask

    initial begin
        bus.pc_in       = '0;
        bus.fetch_start = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.ir_ack      = 1'b0;
        repeat (2) tick();
        check_reset("rst");
        rst = 1'b0;
        tick();

        // Zero-wait fetch: 3 cycles from fetch_start to instr_valid.
        start(32'h40);
        finish_xfer(0, 0, 32'h8C22_0004, 32'h40);
        chk("pc4_0x44", bus.pc_plus4, 32'h44);
        ack();
        chk("ack_clear", 32'(bus.instr_valid), 32'd0);

        // Ready held low for 3 cycles.
        start(32'h40);
        finish_xfer(3, 0, 32'h1111_2222, 32'h40);

        // HOLD without ack ignores fetch_start.
        bus.pc_in = 32'h80; bus.fetch_start = 1'b1;
        tick();
        bus.fetch_start = 1'b0;
        chk("hold_ignore_req", 32'(bus.imem_req), 32'd0);
        chk("hold_ignore_valid", 32'(bus.instr_valid), 32'd1);
        chk("hold_ir_stable", bus.ir_out, 32'h1111_2222);

        // Back-to-back: ack + fetch_start together.
        bus.pc_in = 32'h44; bus.fetch_start = 1'b1; bus.ir_ack = 1'b1;
        tick();
        bus.fetch_start = 1'b0; bus.ir_ack = 1'b0;
        chk("b2b_req", 32'(bus.imem_req), 32'd1);
        chk("b2b_addr", bus.imem_addr, 32'h44);
        chk("b2b_valid", 32'(bus.instr_valid), 32'd0);
        bus.pc_in = 32'h90; bus.fetch_start = 1'b1;
        tick();
        bus.fetch_start = 1'b0;
        chk("busy_ignore_addr", bus.imem_addr, 32'h44);
        finish_xfer(0, 1, 32'h3333_4444, 32'h44);
        ack();

        // Misaligned address.
        exp_q.push_back('{is_fault: 1'b1, ir: 32'h0, pc: 32'h42, pc4: 32'h46});
        start(32'h42);
        chk("mis_fault", 32'(bus.fault), 32'd1);
        chk("mis_req", 32'(bus.imem_req), 32'd0);
        chk("mis_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("mis_pulse", 32'(bus.fault), 32'd0);
        chk("mis_req2", 32'(bus.imem_req), 32'd0);

        // Top-of-memory wrap of pc_plus4.
        start(32'hFFFF_FFFC);
        finish_xfer(1, 2, 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_pc4", bus.pc_plus4, 32'h0);
        ack();

        // Reset during WAIT abandons the fetch; stray rvalid ignored.
        start(32'h100);
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("midrst");
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h5555_AAAA;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("stray_valid", 32'(bus.instr_valid), 32'd0);
        chk("stray_ir", bus.ir_out, 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // Data on the 15th WAIT cycle wins over expiry.
        start(32'h300);
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        repeat (14) tick();
        exp_q.push_back('{is_fault: 1'b0, ir: 32'hCAFE_F00D, pc: 32'h300, pc4: 32'h304});
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("tmo_edge_fault", 32'(bus.fault), 32'd0);
        chk("tmo_edge_valid", 32'(bus.instr_valid), 32'd1);
        ack();

        // No response: fault after the 15th WAIT cycle.
        start(32'h200);
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("tmo_early", 32'(bus.fault), 32'd0);
        end
        exp_q.push_back('{is_fault: 1'b1, ir: 32'h0, pc: 32'h300, pc4: 32'h304});
        tick();
        chk("tmo_fault", 32'(bus.fault), 32'd1);
        chk("tmo_busy", 32'(bus.busy), 32'd0);
        chk("tmo_ir", bus.ir_out, 32'd0);
        tick();
        chk("tmo_pulse", 32'(bus.fault), 32'd0);
`endif

        repeat (2) tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
